sap_sequencer: RTL and testbench

SAP_SEQUENCER -- requirements
Module: sap_sequencer

---
 rtl/sap_sequencer_if.sv | 28 ++
 rtl/sap_sequencer.sv | 137 +++++++++++++
 tb/tb_sap_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sap_sequencer_if.sv
// sap_sequencer_if -- signal bundle between the SAP-1 sequencer and its user.
//   instruction  [3:0]  opcode from IR upper nibble (valid from T4 onward)
//   zero_flag           ALU zero flag, consumed combinationally in T4
//   step_mode           1 = manual single-step, 0 = free-run
//   step                advance enable in manual mode, level-sampled per edge
//   control_word [12:0] {Lp,Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   t_state      [5:0]  one-hot T-state (bit0 = T1), zero while halted
//   halted              high in HALTED
// master drives the inputs of the sequencer; slave is the sequencer itself.
interface sap_sequencer_if;
  logic [3:0]  instruction;
  logic        zero_flag;
  logic        step_mode;
  logic        step;
  logic [12:0] control_word;
  logic [5:0]  t_state;
  logic        halted;

  modport master (
    output instruction, zero_flag, step_mode, step,
    input  control_word, t_state, halted
  );

  modport slave (
    input  instruction, zero_flag, step_mode, step,
    output control_word, t_state, halted
  );
endinterface

// File: rtl/sap_sequencer.sv
// sap_sequencer -- SAP-1 ring-counter / control-matrix sequencer.
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous active-high; forces T1 immediately
//   bus    sap_sequencer_if.slave (instruction, zero_flag, step_mode, step in;
//          control_word, t_state, halted out)
// Build option:
//   SAP_EARLY_END_EN  variable-length instructions: LDA ends at T5, ADD/SUB at
//                     T6, everything else at T4. Undefined = fixed T1..T6.
module sap_sequencer (
  input  logic            clock,
  input  logic            reset,
  sap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_T1     = 3'd0,
    S_T2     = 3'd1,
    S_T3     = 3'd2,
    S_T4     = 3'd3,
    S_T5     = 3'd4,
    S_T6     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [12:0] CW_NOP    = 13'b0001111100011;
  localparam logic [12:0] CW_T1     = 13'b0010111100011;
  localparam logic [12:0] CW_T2     = 13'b0101111100011;
  localparam logic [12:0] CW_T3     = 13'b0001001100011;
  localparam logic [12:0] CW_T4_MEM = 13'b0000110100011;  // LDA/ADD/SUB: IR addr -> MAR
  localparam logic [12:0] CW_T4_OUT = 13'b0001111110010;
  localparam logic [12:0] CW_T4_JMP = 13'b1001110100011;
  localparam logic [12:0] CW_T5_LDA = 13'b0001011000011;
  localparam logic [12:0] CW_T5_ALU = 13'b0001011100001;  // ADD/SUB: RAM -> B
  localparam logic [12:0] CW_T6_ADD = 13'b0001111000111;
  localparam logic [12:0] CW_T6_SUB = 13'b0001111001111;

  state_t state, state_nxt;
  logic   advance;
  logic   is_mem_op;  // opcodes that need a T5

  assign advance   = !bus.step_mode || bus.step;
  assign is_mem_op = (bus.instruction == OP_LDA) || (bus.instruction == OP_ADD) ||
                     (bus.instruction == OP_SUB);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_T1;
    else       state <= state_nxt;
  end

  // Next state. The only opcode-dependent decisions are taken at the T4/T5
  // edges; HALT is sticky until reset.
  always_comb begin
    state_nxt = state;
    if (advance) begin
      case (state)
        S_T1: state_nxt = S_T2;
        S_T2: state_nxt = S_T3;
        S_T3: state_nxt = S_T4;
        S_T4: begin
          if (bus.instruction == OP_HLT) state_nxt = S_HALTED;
`ifdef SAP_EARLY_END_EN
          else if (is_mem_op)            state_nxt = S_T5;
          else                           state_nxt = S_T1;
`else
          else                           state_nxt = S_T5;
`endif
        end
        S_T5: begin
`ifdef SAP_EARLY_END_EN
          if ((bus.instruction == OP_ADD) || (bus.instruction == OP_SUB))
            state_nxt = S_T6;
          else
            state_nxt = S_T1;
`else
          state_nxt = S_T6;
`endif
        end
        S_T6:     state_nxt = S_T1;
        S_HALTED: state_nxt = S_HALTED;
        default:  state_nxt = S_T1;
      endcase
    end
  end

  // Outputs: purely a decode of state, opcode and zero flag.
  always_comb begin
    bus.control_word = CW_NOP;
    bus.t_state      = 6'b000000;
    bus.halted       = 1'b0;
    case (state)
      S_T1: begin
        bus.t_state      = 6'b000001;
        bus.control_word = CW_T1;
      end
      S_T2: begin
        bus.t_state      = 6'b000010;
        bus.control_word = CW_T2;
      end
      S_T3: begin
        bus.t_state      = 6'b000100;
        bus.control_word = CW_T3;
      end
      S_T4: begin
        bus.t_state = 6'b001000;
        if (is_mem_op)                    bus.control_word = CW_T4_MEM;
        else if (bus.instruction == OP_OUT) bus.control_word = CW_T4_OUT;
        else if (bus.instruction == OP_JMP) bus.control_word = CW_T4_JMP;
        else if ((bus.instruction == OP_JZ) && bus.zero_flag)
                                          bus.control_word = CW_T4_JMP;
      end
      S_T5: begin
        bus.t_state = 6'b010000;
        if (bus.instruction == OP_LDA) bus.control_word = CW_T5_LDA;
        else if ((bus.instruction == OP_ADD) || (bus.instruction == OP_SUB))
                                       bus.control_word = CW_T5_ALU;
      end
      S_T6: begin
        bus.t_state = 6'b100000;
        if (bus.instruction == OP_ADD)      bus.control_word = CW_T6_ADD;
        else if (bus.instruction == OP_SUB) bus.control_word = CW_T6_SUB;
      end
      S_HALTED: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sap_sequencer.sv
module tb_sap_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  sap_sequencer_if bus ();

  sap_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [3:0]  instr;
    logic        zf;
    int          tidx;   // 1..6
    logic [12:0] cw;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  int   nv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // manual single step pulse, leaves us at a negedge after the edge
  task automatic step_once();
    bus.step = 1'b1;
    @(negedge clock);
    bus.step = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [3:0] i, input logic z,
                         input int t, input logic [12:0] c);
    vecs[nv] = '{name: n, instr: i, zf: z, tidx: t, cw: c};
    nv++;
  endtask

  logic [5:0] exp_ts;
  logic [5:0] ts_seq [7];
  logic [12:0] cw_seq [7];

  initial begin
    bus.instruction = 4'b0000;
    bus.zero_flag   = 1'b0;
    bus.step_mode   = 1'b1;
    bus.step        = 1'b0;

    nv = 0;
    add_vec("T1_fetch",  4'b0101, 1'b0, 1, 13'b0010111100011);
    add_vec("T2_fetch",  4'b0001, 1'b0, 2, 13'b0101111100011);
    add_vec("T3_fetch",  4'b1110, 1'b1, 3, 13'b0001001100011);
    add_vec("T4_LDA",    4'b0000, 1'b0, 4, 13'b0000110100011);
    add_vec("T4_ADD",    4'b0001, 1'b0, 4, 13'b0000110100011);
    add_vec("T4_SUB",    4'b0010, 1'b1, 4, 13'b0000110100011);
    add_vec("T4_OUT",    4'b1110, 1'b0, 4, 13'b0001111110010);
    add_vec("T4_JMP",    4'b0011, 1'b0, 4, 13'b1001110100011);
    add_vec("T4_JZ_z1",  4'b0100, 1'b1, 4, 13'b1001110100011);
    add_vec("T4_JZ_z0",  4'b0100, 1'b0, 4, 13'b0001111100011);
    add_vec("T4_undef",  4'b0101, 1'b1, 4, 13'b0001111100011);
    add_vec("T4_undefD", 4'b1101, 1'b0, 4, 13'b0001111100011);
    add_vec("T4_HLT",    4'b1111, 1'b0, 4, 13'b0001111100011);
    add_vec("T5_LDA",    4'b0000, 1'b0, 5, 13'b0001011000011);
    add_vec("T5_ADD",    4'b0001, 1'b0, 5, 13'b0001011100001);
    add_vec("T5_SUB",    4'b0010, 1'b0, 5, 13'b0001011100001);
    add_vec("T6_ADD",    4'b0001, 1'b0, 6, 13'b0001111000111);
    add_vec("T6_SUB",    4'b0010, 1'b1, 6, 13'b0001111001111);
`ifndef SAP_EARLY_END_EN
    add_vec("T5_OUT",    4'b1110, 1'b0, 5, 13'b0001111100011);
    add_vec("T5_JZ",     4'b0100, 1'b1, 5, 13'b0001111100011);
    add_vec("T6_LDA",    4'b0000, 1'b0, 6, 13'b0001111100011);
    add_vec("T6_JMP",    4'b0011, 1'b0, 6, 13'b0001111100011);
`endif

    // reset state
    #2;
    check("rst_tstate", bus.t_state, 6'b000001);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_cw", bus.control_word, 13'b0010111100011);

    // step inputs ignored while in reset
    bus.step_mode = 1'b0;
    bus.step      = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ignores_step", bus.t_state, 6'b000001);
    bus.step_mode = 1'b1;
    bus.step      = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // table: walk to target T-state in manual mode, then check decode
    for (int v = 0; v < nv; v++) begin
      do_reset();
      bus.instruction = vecs[v].instr;
      bus.zero_flag   = vecs[v].zf;
      for (int s = 1; s < vecs[v].tidx; s++) step_once();
      exp_ts = 6'b000001 << (vecs[v].tidx - 1);
      check({vecs[v].name, "_ts"}, bus.t_state, exp_ts);
      check({vecs[v].name, "_cw"}, bus.control_word, vecs[v].cw);
    end

    // free-run ADD sequence
    ts_seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    cw_seq = '{13'b0010111100011, 13'b0101111100011, 13'b0001001100011,
               13'b0000110100011, 13'b0001011100001, 13'b0001111000111,
               13'b0010111100011};
    do_reset();
    bus.instruction = 4'b0001;
    bus.zero_flag   = 1'b0;
    bus.step_mode   = 1'b0;
    check("add_run_ts0", bus.t_state, ts_seq[0]);
    for (int k = 1; k < 7; k++) begin
      @(negedge clock);
      check($sformatf("add_run_ts%0d", k), bus.t_state, ts_seq[k]);
      check($sformatf("add_run_cw%0d", k), bus.control_word, cw_seq[k]);
    end

    // JZ zero_flag toggled mid-T4 changes only the control word
    bus.step_mode = 1'b1;
    do_reset();
    bus.instruction = 4'b0100;
    repeat (3) step_once();
    bus.zero_flag = 1'b1; #1;
    check("jz_mid_z1", bus.control_word, 13'b1001110100011);
    bus.zero_flag = 1'b0; #1;
    check("jz_mid_z0", bus.control_word, 13'b0001111100011);
    check("jz_mid_ts", bus.t_state, 6'b001000);

    // HALT: free-run, stuck after the T4 edge until reset
    do_reset();
    bus.instruction = 4'b1111;
    bus.step_mode   = 1'b0;
    repeat (4) @(negedge clock);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("hlt_halted%0d", k), bus.halted, 1'b1);
      check($sformatf("hlt_ts%0d", k), bus.t_state, 6'b000000);
      check($sformatf("hlt_cw%0d", k), bus.control_word, 13'b0001111100011);
      @(negedge clock);
    end
    bus.instruction = 4'b0000;
    @(negedge clock);
    check("hlt_sticky", bus.halted, 1'b1);
    reset = 1'b1; #1;
    check("hlt_rst_ts", bus.t_state, 6'b000001);
    check("hlt_rst_halted", bus.halted, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("hlt_rst_to_t2", bus.t_state, 6'b000010);

    // undefined opcode never halts over many cycles
    do_reset();
    bus.instruction = 4'b1000;
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      check($sformatf("undef_nohalt%0d", k), bus.halted, 1'b0);
    end
`ifndef SAP_EARLY_END_EN
    check("undef_wrap_ts", bus.t_state, 6'b000010);
`endif

    // manual hold in T3, then a single step
    bus.step_mode = 1'b1;
    bus.instruction = 4'b0001;
    do_reset();
    step_once(); step_once();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("hold_t3_%0d", k), bus.t_state, 6'b000100);
    end
    step_once();
    check("step_to_t4", bus.t_state, 6'b001000);
    @(negedge clock);
    check("step_held_t4", bus.t_state, 6'b001000);

    // async reset mid-T5, seen before the next edge
    repeat (1) step_once();
    check("pre_rst_t5", bus.t_state, 6'b010000);
    #2 reset = 1'b1;
    #1;
    check("async_rst_t5", bus.t_state, 6'b000001);
    check("async_rst_cw", bus.control_word, 13'b0010111100011);
    @(negedge clock);
    reset = 1'b0;

`ifdef SAP_EARLY_END_EN
    // OUT is a 4-cycle instruction, LDA a 5-cycle one
    bus.step_mode = 1'b0;
    do_reset();
    bus.instruction = 4'b1110;
    repeat (3) @(negedge clock);
    check("ee_out_t4", bus.t_state, 6'b001000);
    @(negedge clock);
    check("ee_out_t1", bus.t_state, 6'b000001);
    bus.instruction = 4'b0000;
    repeat (4) @(negedge clock);
    check("ee_lda_t5", bus.t_state, 6'b010000);
    @(negedge clock);
    check("ee_lda_t1", bus.t_state, 6'b000001);
    bus.instruction = 4'b0100;
    bus.zero_flag   = 1'b0;
    repeat (4) @(negedge clock);
    check("ee_jz_t1", bus.t_state, 6'b000001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
